// File: rtl/fifo_buffer_if.sv
// fifo_buffer_if: push/pop bus for fifo_buffer.
// The master side issues write/read/data_in and observes the buffer state.
// The slave side is the buffer itself.
// When FIFO_ERR_FLAGS_EN is defined, the sticky overflow/underflow flags are also carried.
interface fifo_buffer_if #(
  parameter int FIFO_SIZE = 8,
  parameter int DATA_W    = 8
);
  localparam int CNT_W = $clog2(FIFO_SIZE) + 1;

  logic              write;
  logic              read;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;
`endif

  modport master (
    output write,
    output read,
    output data_in,
    input  data_out,
    input  full,
    input  empty,
    input  count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  overflow,
    input  underflow
`endif
  );

  modport slave (
    input  write,
    input  read,
    input  data_in,
    output data_out,
    output full,
    output empty,
    output count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output overflow,
    output underflow
`endif
  );
endinterface

// File: rtl/fifo_buffer.sv
// fifo_buffer: circular-array FIFO with registered data_out and an occupancy counter.
// Words leave in arrival order.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
// A pop from an empty buffer is always rejected, so data_in never bypasses to data_out.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow flags.
module fifo_buffer #(
  parameter int FIFO_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic           clk,
  input  logic           reset,
  fifo_buffer_if.slave   bus
);
  localparam int PTR_W = $clog2(FIFO_SIZE);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_SIZE];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  assign full_s  = (count_q == CNT_W'(FIFO_SIZE));
  assign empty_s = (count_q == CNT_W'(0));

  // Decide which requests are accepted and form the next pointer/count/data state.
  always_comb begin
    push_s     = 1'b0;
    pop_s      = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    // A full buffer can still take a word if a pop frees the head slot in the same edge.
    if (bus.write && (!full_s || bus.read)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end

    if (bus.read && !empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array: written on accepted pushes only and never cleared by reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // Pointers, occupancy and output word: cleared by reset, otherwise loaded from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.count    = count_q;
  assign bus.full     = full_s;
  assign bus.empty    = empty_s;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Next sticky flags: a write into a full buffer with no pop, or any read of an empty one.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.write && full_s && !bus.read) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if (bus.read && empty_s) begin
      underflow_d = 1'b1;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Sticky error flags: released only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: scoreboard bench for fifo_buffer.
// The driver applies stimulus on the falling edge.
// A queue-based reference model then computes the expected state after the next rising edge,
// and that expectation is pushed to a scoreboard.
// The monitor checks the outputs shortly after each rising edge.
module tb_fifo_buffer;
  localparam int FIFO_SIZE = 8;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = $clog2(FIFO_SIZE) + 1;

  logic clk;
  logic reset;

  fifo_buffer_if #(.FIFO_SIZE(FIFO_SIZE), .DATA_W(DATA_W)) bus ();

  fifo_buffer #(.FIFO_SIZE(FIFO_SIZE), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [7:0]  dout;
    int          cnt;
    bit          full;
    bit          empty;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   edge_cnt = 0;

  // Reference model state: contents in arrival order, last popped word, sticky flags.
  logic [7:0] m_q[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_ovf  = 1'b0;
  bit         m_unf  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Monitor: after each rising edge, compare the DUT against the expectation recorded for that edge.
  always begin
    @(posedge clk);
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      check("data_out", int'(bus.data_out), int'(e.dout));
      check("count",    int'(bus.count),    e.cnt);
      check("full",     int'(bus.full),     int'(e.full));
      check("empty",    int'(bus.empty),    int'(e.empty));
`ifdef FIFO_ERR_FLAGS_EN
      check("overflow",  int'(bus.overflow),  int'(e.ovf));
      check("underflow", int'(bus.underflow), int'(e.unf));
`endif
    end
  end

  // Apply one cycle of stimulus, advance the model, and queue the expected post-edge state.
  task automatic drive(input bit w, input bit r, input logic [7:0] d, input bit rs);
    exp_t e;
    bit   was_full;
    bit   was_empty;
    @(negedge clk);
    bus.write   = w;
    bus.read    = r;
    bus.data_in = d;
    reset       = rs;
    if (rs) begin
      m_q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      was_full  = (m_q.size() == FIFO_SIZE);
      was_empty = (m_q.size() == 0);
      if (w && was_full && !r) m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      if (r && !was_empty) m_dout = m_q.pop_front();
      if (w && (!was_full || r)) m_q.push_back(d);
    end
    e.cyc   = edge_cnt + 1;
    e.dout  = m_dout;
    e.cnt   = m_q.size();
    e.full  = (m_q.size() == FIFO_SIZE);
    e.empty = (m_q.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic pop();
    drive(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  // Directed scenarios first, then biased random traffic with occasional resets.
  initial begin
    logic [7:0] pat [4];
    int         pw;
    int         pr;
    reset       = 1'b1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = 8'h00;

    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Order check with extreme bit patterns, then an underflow pop.
    pat[0] = 8'hFF; pat[1] = 8'h00; pat[2] = 8'hF0; pat[3] = 8'h0F;
    for (int i = 0; i < 4; i++) push(pat[i]);
    for (int i = 0; i < 4; i++) pop();
    pop();

    // Fill, overflow attempt, drain.
    for (int i = 1; i <= 8; i++) push(8'(i));
    push(8'h09);
    for (int i = 0; i < 8; i++) pop();

    // Full with simultaneous push and pop, then drain across the pointer wrap.
    for (int i = 1; i <= 8; i++) push(8'(i));
    drive(1'b1, 1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 8; i++) pop();

    // Empty with simultaneous push and pop: only the push takes effect.
    drive(1'b1, 1'b1, 8'h81, 1'b0);
    pop();

    // Reset in the middle of traffic, then a clean round trip.
    push(8'h81);
    push(8'h80);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    push(8'h3C);
    pop();

    // Random traffic: the bias changes every 64 cycles so full and empty are both reached often.
    pw = 50;
    pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       begin pw = 85; pr = 30; end
          1:       begin pw = 30; pr = 85; end
          default: begin pw = 60; pr = 60; end
        endcase
      end
      drive(($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0,
            8'($urandom),
            ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parameterized first-in-first-out buffer with the same push/pop interface as the team's LIFO buffer. Words leave in arrival order, not reverse order. It is the ordered-delivery counterpart for stream paths that must preserve sequence, e.g. between a producer and a slower consumer on one clock. Storage is a circular register array with read/write pointers and an occupancy counter.

## Interface
- FIFO_SIZE, 8, number of storage words; power of two, ≥2
- DATA_W, 8, word width in bits
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears pointers, count, flags, data_out
- write  input  1  push request; data_in stored on the edge when accepted
- read  input  1  pop request; oldest word moved to data_out on the edge when accepted
- data_in  input  DATA_W  word to push
- data_out  output  DATA_W  last popped word, registered; holds between pops
- full  output  1  count == FIFO_SIZE
- empty  output  1  count == 0
- count  output  $clog2(FIFO_SIZE)+1  current occupancy, 0..FIFO_SIZE
- overflow  output  1  sticky error flag; present only with FIFO_ERR_FLAGS_EN
- underflow  output  1  sticky error flag; present only with FIFO_ERR_FLAGS_EN

## Operation
- State: mem[FIFO_SIZE], wr_ptr, rd_ptr (each $clog2(FIFO_SIZE) bits, wrap modulo FIFO_SIZE naturally), count.
- Push accepted when write && (!full || read). On the edge: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
- Pop accepted when read && !empty. On the edge: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with write && read: both are accepted. The popped word is the old head. The new word takes the freed slot. count stays FIFO_SIZE.
- Empty with write && read: the pop is rejected and the push is accepted. data_out holds its value. count becomes 1. There is no bypass of data_in to data_out.
- Full with write && !read: the push is dropped. Memory, pointers and count are unchanged.
- Empty with read && !write: the pop is dropped. data_out holds its value.
- full and empty are combinational decodes of count.
- Reset asserted mid-operation: pointers, count and data_out go to 0 immediately. empty=1, full=0. Memory contents are not cleared and are unreachable afterwards.

## Timing
- Reset values: data_out=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- Push-to-visibility: a word written at edge N can be popped at edge N+1. It appears on data_out after edge N+1.
- Pop latency: data_out valid one edge after read is sampled high with !empty. No combinational path from read to data_out.
- full, empty and count update on the same edge as the accepted operation.
- Throughput: one push and one pop per cycle, sustained.
- Release of reset is synchronous to the next rising edge. The first operation is sampled at the first edge after reset falls.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - overflow sets on an edge with write && full && !read.
  - underflow sets on an edge with read && empty.
  - Both flags are sticky and clear only on reset.
  - A dropped operation still has no other effect.
- FIFO_ERR_FLAGS_EN undefined: overflow and underflow ports and logic are absent. Dropped operations are silent.

## Test plan
- Reset then push 8'hFF, 8'h00, 8'hF0, 8'h0F, then pop four times -> data_out sequence FF, 00, F0, 0F. count 4→0. empty=1 after the last pop.
- Pop a fifth time while empty -> data_out stays 0F, count stays 0. underflow=1 with FIFO_ERR_FLAGS_EN.
- Push 8 words 8'h01..8'h08 -> full=1, count=8. Ninth push of 8'h09 is dropped. overflow=1 with FIFO_ERR_FLAGS_EN. Eight pops return 01..08.
- Full FIFO holding 01..08, write=read=1 with data_in=8'hAA for one cycle -> data_out=01, count=8. Subsequent pops return 02..08 then AA (exercises pointer wrap).
- Empty FIFO, write=read=1 with data_in=8'h81 -> count=1, data_out unchanged. The next pop returns 81.
- Push 8'h81, 8'h80, assert reset for one cycle -> count=0, empty=1, data_out=0, flags cleared. A following push/pop of 8'h3C returns 3C.
